// File: rtl/sdfm_pkg.sv
// Shared types and helpers for the sigma-delta filter channel group.
package sdfm_pkg;

   localparam int unsigned ACCW = 26;

   typedef enum logic [1:0] {
      SINC1 = 2'd0,
      SINC2 = 2'd1,
      SINC3 = 2'd2
   } filt_order_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
      end
      return r;
   endfunction

   // Register code 3 is an alias for sinc3.
   function automatic filt_order_e to_order(input logic [1:0] st);
      filt_order_e o;
      case (st)
         2'd0:    o = SINC1;
         2'd1:    o = SINC2;
         default: o = SINC3;
      endcase
      return o;
   endfunction

   // Clamp an accumulator-width value into a dw-bit signed range.
   function automatic logic signed [31:0] saturate(input logic signed [ACCW-1:0] v,
                                                   input int unsigned dw);
      logic signed [63:0] wide;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      wide = {{(64-ACCW){v[ACCW-1]}}, v};
      hi   = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
      lo   = -hi - 64'sd1;
      if (wide > hi)      wide = hi;
      else if (wide < lo) wide = lo;
      return 32'(wide);
   endfunction

endpackage

// File: rtl/sdfm_sinc_core.sv
// One filter channel: sinc1/2/3 CIC decimator, shift/saturate, pending result
// register with overwrite detection, and clock-loss watchdog.
module sdfm_sinc_core
   import sdfm_pkg::*;
#(
   parameter int unsigned DW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          strobe_i,
   input  logic          bit_i,
   input  logic [7:0]    dec_i,
   input  logic [1:0]    st_i,
   input  logic [4:0]    sh_i,
   input  logic [7:0]    wdtlim_i,
   input  logic          err_clr_i,
   input  logic          grant_i,
   output logic          pend_o,
   output logic [DW-1:0] pend_data_o,
   output logic          lost_o,
   output logic          detect_err_o
);

   logic signed [ACCW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic signed [ACCW-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic signed [ACCW-1:0] x, c0, c1, c2, c3, comb, shifted;
   logic signed [31:0]     sat;
   logic [7:0]             cnt_q, cnt_d, wdt_q, wdt_d;
   logic                   pend_q, pend_d, lost_q, lost_d, det_q, det_d;
   logic [DW-1:0]          pend_data_q, pend_data_d;
   logic                   stb, complete, lost_set, det_set;
   filt_order_e            order;

   always_comb begin
      stb      = en_i & strobe_i;
      x        = bit_i ? ACCW'(1) : {ACCW{1'b1}};
      order    = to_order(st_i);
      i1_d     = i1_q;
      i2_d     = i2_q;
      i3_d     = i3_q;
      cnt_d    = cnt_q;
      complete = 1'b0;

      // Integrator cascade is pipelined: each stage adds the previous stage's old value.
      if (stb) begin
         i1_d     = i1_q + x;
         i2_d     = i2_q + i1_q;
         i3_d     = i3_q + i2_q;
         cnt_d    = cnt_q + 8'd1;
         complete = (cnt_q == dec_i);
         if (complete) cnt_d = '0;
      end

      case (order)
         SINC1:   c0 = i1_d;
         SINC2:   c0 = i2_d;
         default: c0 = i3_d;
      endcase
      c1 = c0 - d1_q;
      c2 = c1 - d2_q;
      c3 = c2 - d3_q;
      case (order)
         SINC1:   comb = c1;
         SINC2:   comb = c2;
         default: comb = c3;
      endcase
      shifted = comb >>> sh_i;
      sat     = saturate(shifted, DW);

      d1_d        = d1_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      lost_set    = 1'b0;
      if (complete) begin
         d1_d        = c0;
         d2_d        = c1;
         d3_d        = c2;
         pend_d      = 1'b1;
         pend_data_d = DW'(sat);
         lost_set    = pend_q & ~grant_i;
      end else if (grant_i) begin
         pend_d = 1'b0;
      end

      // Watchdog counts idle cycles and saturates at the limit; it flags only on arrival.
      wdt_d   = wdt_q;
      det_set = 1'b0;
      if ((wdtlim_i == 8'd0) || strobe_i) begin
         wdt_d = '0;
      end else if (wdt_q < wdtlim_i) begin
         wdt_d   = wdt_q + 8'd1;
         det_set = (wdt_q == (wdtlim_i - 8'd1));
      end

      lost_d = err_clr_i ? 1'b0 : (lost_q | lost_set);
      det_d  = err_clr_i ? 1'b0 : (det_q | (det_set & en_i));

      if (!en_i) begin
         i1_d        = '0;
         i2_d        = '0;
         i3_d        = '0;
         d1_d        = '0;
         d2_d        = '0;
         d3_d        = '0;
         cnt_d       = '0;
         pend_d      = 1'b0;
         pend_data_d = '0;
         wdt_d       = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         cnt_q       <= '0;
         wdt_q       <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         lost_q      <= 1'b0;
         det_q       <= 1'b0;
      end else begin
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         cnt_q       <= cnt_d;
         wdt_q       <= wdt_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         lost_q      <= lost_d;
         det_q       <= det_d;
      end
   end

   assign pend_o       = pend_q;
   assign pend_data_o  = pend_data_q;
   assign lost_o       = lost_q;
   assign detect_err_o = det_q;

endmodule

// File: rtl/sdfm_chgroup.sv
// N-channel sigma-delta filter group: per-channel sinc cores merged through a
// round-robin arbiter into one channel-tagged first-word-fall-through FIFO.
module sdfm_chgroup
   import sdfm_pkg::*;
#(
   parameter  int unsigned NCH        = 4,
   parameter  int unsigned DW         = 16,
   parameter  int unsigned FIFO_DEPTH = 16,
   localparam int unsigned CHW        = (NCH > 1) ? clog2(NCH) : 1,
   localparam int unsigned AW         = clog2(FIFO_DEPTH)
) (
   input  logic           SYSCLK,
   input  logic           SYSRST,
   input  logic [NCH-1:0] sd_clk_en,
   input  logic [NCH-1:0] sd_dsd_in,
   input  logic [NCH-1:0] reg_filten,
   input  logic [7:0]     reg_filtdec,
   input  logic [1:0]     reg_filtst,
   input  logic [4:0]     reg_filtsh,
   input  logic [7:0]     reg_wdtlim,
   input  logic [NCH-1:0] err_clr,
   input  logic           fifo_rd,
   output logic [DW-1:0]  fifo_rdata,
   output logic [CHW-1:0] fifo_rch,
   output logic           fifo_empty,
   output logic           fifo_full,
   output logic [AW:0]    fifo_level,
   output logic [NCH-1:0] lost,
   output logic [NCH-1:0] detect_err
);

   localparam int unsigned LW = AW + 1;
   localparam int unsigned IW = CHW + 1;

   logic [NCH-1:0] pend, grant;
   logic [DW-1:0]  pend_data [NCH];
   logic [CHW-1:0] rr_q, rr_d, gnt_idx;
   logic [IW-1:0]  idx;
   logic           push, pop, can_push;
   logic [DW-1:0]  mem_data [FIFO_DEPTH];
   logic [CHW-1:0] mem_ch [FIFO_DEPTH];
   logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic           empty_q, empty_d, full_q, full_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic [CHW-1:0] rch_q, rch_d;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      sdfm_sinc_core #(.DW(DW)) u_core (
         .clk_i        (SYSCLK),
         .rst_i        (SYSRST),
         .en_i         (reg_filten[g]),
         .strobe_i     (sd_clk_en[g]),
         .bit_i        (sd_dsd_in[g]),
         .dec_i        (reg_filtdec),
         .st_i         (reg_filtst),
         .sh_i         (reg_filtsh),
         .wdtlim_i     (reg_wdtlim),
         .err_clr_i    (err_clr[g]),
         .grant_i      (grant[g]),
         .pend_o       (pend[g]),
         .pend_data_o  (pend_data[g]),
         .lost_o       (lost[g]),
         .detect_err_o (detect_err[g])
      );
   end

   // Round-robin search starting at the pointer; a same-cycle pop frees a full slot.
   always_comb begin
      can_push = ~full_q | fifo_rd;
      push     = 1'b0;
      gnt_idx  = '0;
      idx      = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         idx = IW'(rr_q) + IW'(k);
         if (idx >= IW'(NCH)) idx = idx - IW'(NCH);
         if (!push && can_push && pend[CHW'(idx)]) begin
            push    = 1'b1;
            gnt_idx = CHW'(idx);
         end
      end
      grant = '0;
      if (push) grant[gnt_idx] = 1'b1;
      rr_d = rr_q;
      if (push) rr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
   end

   // FIFO bookkeeping; the head is held in registers and refreshed whenever it changes.
   always_comb begin
      pop    = fifo_rd & (~empty_q | push);
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      empty_d = (level_d == '0);
      full_d  = (level_d == LW'(FIFO_DEPTH));
      rdata_d = rdata_q;
      rch_d   = rch_q;
      if (!empty_d) begin
         if (push && (rptr_d == wptr_q)) begin
            rdata_d = pend_data[gnt_idx];
            rch_d   = gnt_idx;
         end else begin
            rdata_d = mem_data[rptr_d];
            rch_d   = mem_ch[rptr_d];
         end
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (push) begin
         mem_data[wptr_q] <= pend_data[gnt_idx];
         mem_ch[wptr_q]   <= gnt_idx;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (SYSRST) begin
         rr_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         rdata_q <= '0;
         rch_q   <= '0;
      end else begin
         rr_q    <= rr_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         rdata_q <= rdata_d;
         rch_q   <= rch_d;
      end
   end

   assign fifo_rdata = rdata_q;
   assign fifo_rch   = rch_q;
   assign fifo_empty = empty_q;
   assign fifo_full  = full_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_sdfm_chgroup.sv
// Directed bench for sdfm_chgroup with hand-computed CIC results.
module tb_sdfm_chgroup;

   logic        SYSCLK = 1'b0;
   logic        SYSRST;
   logic [3:0]  sd_clk_en, sd_dsd_in, reg_filten, err_clr;
   logic [7:0]  reg_filtdec, reg_wdtlim;
   logic [1:0]  reg_filtst;
   logic [4:0]  reg_filtsh;
   logic        fifo_rd;
   logic [15:0] fifo_rdata;
   logic [1:0]  fifo_rch;
   logic        fifo_empty, fifo_full;
   logic [4:0]  fifo_level;
   logic [3:0]  lost, detect_err;

   int n_total = 0;
   int n_bad   = 0;

   always #5 SYSCLK = ~SYSCLK;

   sdfm_chgroup dut (
      .SYSCLK      (SYSCLK),
      .SYSRST      (SYSRST),
      .sd_clk_en   (sd_clk_en),
      .sd_dsd_in   (sd_dsd_in),
      .reg_filten  (reg_filten),
      .reg_filtdec (reg_filtdec),
      .reg_filtst  (reg_filtst),
      .reg_filtsh  (reg_filtsh),
      .reg_wdtlim  (reg_wdtlim),
      .err_clr     (err_clr),
      .fifo_rd     (fifo_rd),
      .fifo_rdata  (fifo_rdata),
      .fifo_rch    (fifo_rch),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .fifo_level  (fifo_level),
      .lost        (lost),
      .detect_err  (detect_err)
   );

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SYSCLK);
      #1;
   endtask

   task automatic do_reset();
      SYSRST      = 1'b1;
      sd_clk_en   = '0;
      sd_dsd_in   = '0;
      reg_filten  = '0;
      reg_filtdec = '0;
      reg_filtst  = '0;
      reg_filtsh  = '0;
      reg_wdtlim  = '0;
      err_clr     = '0;
      fifo_rd     = 1'b0;
      tick();
      SYSRST = 1'b0;
   endtask

   task automatic strobe(input logic [3:0] m, input logic [3:0] b);
      sd_clk_en = m;
      sd_dsd_in = b;
      tick();
      sd_clk_en = '0;
      tick();
   endtask

   task automatic strobe_n(input int n, input logic [3:0] m, input logic [3:0] b);
      for (int i = 0; i < n; i++) strobe(m, b);
   endtask

   task automatic pop_only();
      fifo_rd = 1'b1;
      tick();
      fifo_rd = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input int d, input int ch);
      chk({tag, "_nempty"}, fifo_empty, 0);
      chk({tag, "_data"}, $signed(fifo_rdata), d);
      chk({tag, "_ch"}, fifo_rch, ch);
      pop_only();
   endtask

   initial begin
      do_reset();
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_lost", lost, 0);
      chk("rst_det", detect_err, 0);
      chk("rst_rdata", fifo_rdata, 0);
      chk("rst_rch", fifo_rch, 0);

      // ch0 all-ones, R=16, sinc1: every result +16; latency check on the first
      do_reset();
      reg_filten = 4'b0001; reg_filtdec = 8'd15;
      strobe_n(15, 4'b0001, 4'b0001);
      sd_clk_en = 4'b0001; sd_dsd_in = 4'b0001;
      tick();
      sd_clk_en = '0;
      chk("lat_pend_empty", fifo_empty, 1);
      tick();
      chk("lat_written", fifo_empty, 0);
      chk("lat_level", fifo_level, 1);
      pop_chk("s1_o1", 16, 0);
      strobe_n(16, 4'b0001, 4'b0001);
      pop_chk("s1_o2", 16, 0);
      chk("s1_empty", fifo_empty, 1);
      chk("s1_lost", lost, 0);

      // ch0 sinc3: third difference of a cubic ramp settles at R^3 = 4096
      do_reset();
      reg_filten = 4'b0001; reg_filtdec = 8'd15; reg_filtst = 2'd2;
      strobe_n(64, 4'b0001, 4'b0001);
      chk("s3_level", fifo_level, 4);
      pop_only();
      pop_only();
      pop_chk("s3_o3", 4096, 0);
      pop_chk("s3_o4", 4096, 0);

      // ch1 all-zeros, R=256, sinc3: -2^24 steady, saturating / shifting
      do_reset();
      reg_filten = 4'b0010; reg_filtdec = 8'd255; reg_filtst = 2'd2;
      strobe_n(768, 4'b0010, 4'b0000);
      reg_filtsh = 5'd9;
      strobe_n(256, 4'b0010, 4'b0000);
      reg_filtsh = 5'd10;
      strobe_n(256, 4'b0010, 4'b0000);
      chk("sat_level", fifo_level, 5);
      pop_only();
      pop_only();
      pop_chk("sat_sh0", -32768, 1);
      pop_chk("sat_sh9", -32768, 1);
      pop_chk("sat_sh10", -16384, 1);

      // Round robin: ch2 alone moves the pointer to 3, then all four complete together
      do_reset();
      reg_filten = 4'b0100; reg_filtdec = 8'd3;
      strobe_n(4, 4'b0100, 4'b0100);
      pop_chk("rr_solo", 4, 2);
      reg_filten = 4'b1111;
      strobe(4'b1111, 4'b0111);
      strobe(4'b1111, 4'b0011);
      strobe(4'b1111, 4'b0011);
      strobe(4'b1111, 4'b0001);
      for (int i = 0; i < 4; i++) tick();
      chk("rr_level", fifo_level, 4);
      chk("rr_lost", lost, 0);
      pop_chk("rr_0", -4, 3);
      pop_chk("rr_1", 4, 0);
      pop_chk("rr_2", 2, 1);
      pop_chk("rr_3", -2, 2);

      // Full FIFO holds the pending result; a second completion overwrites and flags lost
      do_reset();
      reg_filten = 4'b0100; reg_filtdec = 8'd0;
      strobe_n(16, 4'b0100, 4'b0100);
      chk("full_level", fifo_level, 16);
      chk("full_flag", fifo_full, 1);
      strobe(4'b0100, 4'b0000);
      chk("full_held_lost", lost, 0);
      chk("full_held_level", fifo_level, 16);
      strobe(4'b0100, 4'b0100);
      chk("full_lost", lost, 4'b0100);
      chk("full_level2", fifo_level, 16);
      chk("full_flag2", fifo_full, 1);
      pop_chk("full_p0", 1, 2);
      chk("full_pushpop_level", fifo_level, 16);
      err_clr = 4'b0100;
      tick();
      err_clr = '0;
      chk("full_lost_clr", lost, 0);
      for (int i = 0; i < 16; i++) pop_chk("full_drain", 1, 2);
      chk("full_drained", fifo_empty, 1);

      // Watchdog: flag exactly ten clock edges after the edge that took the last strobe
      do_reset();
      reg_filten = 4'b1000; reg_filtdec = 8'd15; reg_wdtlim = 8'd10;
      strobe_n(5, 4'b1000, 4'b1000);
      chk("wdt_alive", detect_err, 0);
      for (int i = 0; i < 8; i++) tick();
      chk("wdt_edge9", detect_err, 0);
      tick();
      chk("wdt_edge10", detect_err, 4'b1000);
      tick();
      tick();
      chk("wdt_sticky", detect_err, 4'b1000);
      err_clr = 4'b1000;
      tick();
      err_clr = '0;
      chk("wdt_clr", detect_err, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("wdt_stays_clr", detect_err, 0);

      // Reset mid-decimation flushes FIFO; the next run matches a fresh one
      do_reset();
      reg_filten = 4'b0001; reg_filtdec = 8'd15;
      strobe_n(16, 4'b0001, 4'b0001);
      chk("mrst_pre_level", fifo_level, 1);
      strobe_n(8, 4'b0001, 4'b0000);
      SYSRST = 1'b1;
      tick();
      chk("mrst_empty", fifo_empty, 1);
      chk("mrst_level", fifo_level, 0);
      SYSRST = 1'b0;
      strobe_n(16, 4'b0001, 4'b0001);
      chk("mrst_level1", fifo_level, 1);
      pop_chk("mrst_o1", 16, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
